// File: rtl/can_tx_scheduler.sv
// Shares one CAN controller transmit path among NUM_MB one-entry mailboxes.
// The full mailbox with the lowest CAN ID is programmed over Wishbone, then polled and checked.
module can_tx_scheduler #(
    parameter int          NUM_MB    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          POLL_MAX  = 16,
    localparam int         IDX_W     = (NUM_MB > 1) ? $clog2(NUM_MB) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_MB-1:0]    req_valid,
    output logic [NUM_MB-1:0]    req_ready,
    input  logic [NUM_MB*11-1:0] req_id,
    input  logic [NUM_MB*8-1:0]  req_len,
    input  logic [NUM_MB*32-1:0] req_data0,
    input  logic [NUM_MB*32-1:0] req_data1,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    input  logic                 wbm_ack_i,
    output logic                 done_valid,
    output logic [IDX_W-1:0]     done_idx,
    output logic                 done_err,
    output logic                 busy
);

    localparam int PC_W = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, WR_ID, WR_LEN, WR_D0, WR_D1, WR_CMD, POLL, RD_RXID, RD_CLR, DONE
    } state_t;

    state_t            state, state_d;
    logic              gap;        // one idle bus cycle after each acked access
    logic [IDX_W-1:0]  cur_idx;
    logic              err;
    logic              rx_ok;
    logic [PC_W-1:0]   poll_cnt;

    logic [NUM_MB-1:0] mb_full;
    logic [10:0]       mb_id  [NUM_MB];
    logic [7:0]        mb_len [NUM_MB];
    logic [31:0]       mb_d0  [NUM_MB];
    logic [31:0]       mb_d1  [NUM_MB];

    logic              any_full;
    logic [IDX_W-1:0]  win_idx;
    logic [10:0]       win_id;
    logic              bus_act;
    logic [7:0]        bus_off;
    logic              bus_we;
    logic [31:0]       bus_wdat;
    logic              unused_dat;

    assign unused_dat = ^wbm_dat_i[31:11];

    // Lowest ID wins; strict compare keeps the lowest index on ties.
    always_comb begin
        any_full = 1'b0;
        win_idx  = '0;
        win_id   = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_full[i] && (!any_full || mb_id[i] < win_id)) begin
                any_full = 1'b1;
                win_idx  = IDX_W'(i);
                win_id   = mb_id[i];
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state;
        bus_act  = 1'b0;
        bus_off  = 8'h00;
        bus_we   = 1'b0;
        bus_wdat = '0;
        case (state)
            WR_ID:   begin bus_act = 1'b1; bus_off = 8'h08; bus_we = 1'b1; bus_wdat = {21'b0, mb_id[cur_idx]}; end
            WR_LEN:  begin bus_act = 1'b1; bus_off = 8'h0C; bus_we = 1'b1; bus_wdat = {24'b0, mb_len[cur_idx]}; end
            WR_D0:   begin bus_act = 1'b1; bus_off = 8'h10; bus_we = 1'b1; bus_wdat = mb_d0[cur_idx]; end
            WR_D1:   begin bus_act = 1'b1; bus_off = 8'h14; bus_we = 1'b1; bus_wdat = mb_d1[cur_idx]; end
            WR_CMD:  begin bus_act = 1'b1; bus_off = 8'h00; bus_we = 1'b1; bus_wdat = 32'h2; end
            POLL:    begin bus_act = 1'b1; bus_off = 8'h04; end
            RD_RXID: begin bus_act = 1'b1; bus_off = 8'h18; end
            RD_CLR:  begin bus_act = 1'b1; bus_off = 8'h1C; end
            default: ;
        endcase

        case (state)
            IDLE: if (any_full) state_d = WR_ID;
            DONE: state_d = IDLE;
            default: begin
                if (gap) begin
                    case (state)
                        WR_ID:   state_d = WR_LEN;
                        WR_LEN:  state_d = WR_D0;
                        WR_D0:   state_d = WR_D1;
                        WR_D1:   state_d = WR_CMD;
                        WR_CMD:  state_d = POLL;
                        POLL: begin
                            if (rx_ok)                            state_d = RD_RXID;
                            else if (poll_cnt == PC_W'(POLL_MAX)) state_d = DONE;
                            else                                  state_d = POLL;
                        end
                        RD_RXID: state_d = RD_CLR;
                        RD_CLR:  state_d = DONE;
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    assign wbm_cyc_o  = bus_act & ~gap;
    assign wbm_stb_o  = bus_act & ~gap;
    assign wbm_we_o   = bus_act & bus_we;
    assign wbm_adr_o  = bus_act ? BASE_ADDR + {24'b0, bus_off} : '0;
    assign wbm_dat_o  = bus_act ? bus_wdat : '0;
    assign done_valid = (state == DONE);
    assign done_idx   = cur_idx;
    assign done_err   = (state == DONE) & err;
    assign busy       = (state != IDLE);
    assign req_ready  = ~mb_full;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap      <= 1'b0;
            cur_idx  <= '0;
            err      <= 1'b0;
            rx_ok    <= 1'b0;
            poll_cnt <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && any_full)
                cur_idx <= win_idx;
            if (bus_act) begin
                if (gap)
                    gap <= 1'b0;
                else if (wbm_ack_i)
                    gap <= 1'b1;
            end
            if (state == POLL && !gap && wbm_ack_i) begin
                rx_ok <= wbm_dat_i[0];
                if (!wbm_dat_i[0]) begin
                    poll_cnt <= poll_cnt + 1'b1;
                    if (poll_cnt == PC_W'(POLL_MAX - 1))
                        err <= 1'b1;
                end
            end
            if (state == RD_RXID && !gap && wbm_ack_i && wbm_dat_i[10:0] != mb_id[cur_idx])
                err <= 1'b1;
            if (state == DONE) begin
                err      <= 1'b0;
                poll_cnt <= '0;
            end
        end
    end

    // Load and release of different mailboxes in one cycle are independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_full <= '0;
        end else begin
            for (int i = 0; i < NUM_MB; i++) begin
                if (state == DONE && cur_idx == IDX_W'(i))
                    mb_full[i] <= 1'b0;
                else if (req_valid[i] && !mb_full[i])
                    mb_full[i] <= 1'b1;
            end
        end
    end

    // NOTE: payload storage has no reset; it is only read while its full flag is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MB; i++) begin
            if (req_valid[i] && !mb_full[i]) begin
                mb_id[i]  <= req_id[i*11 +: 11];
                mb_len[i] <= req_len[i*8 +: 8];
                mb_d0[i]  <= req_data0[i*32 +: 32];
                mb_d1[i]  <= req_data1[i*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench: Wishbone slave model plus bus/completion scoreboards,
// a vector table of single frames and hand-written multi-cycle sequences.
module tb_can_tx_scheduler;

    localparam int NUM_MB   = 4;
    localparam int POLL_MAX = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_MB-1:0]    req_valid = '0;
    logic [NUM_MB-1:0]    req_ready;
    logic [NUM_MB*11-1:0] req_id = '0;
    logic [NUM_MB*8-1:0]  req_len = '0;
    logic [NUM_MB*32-1:0] req_data0 = '0;
    logic [NUM_MB*32-1:0] req_data1 = '0;
    logic [31:0]          wbm_adr_o, wbm_dat_o;
    logic [31:0]          wbm_dat_i = '0;
    logic                 wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic                 wbm_ack_i = 1'b0;
    logic                 done_valid, done_err, busy;
    logic [1:0]           done_idx;

    can_tx_scheduler #(.NUM_MB(NUM_MB), .BASE_ADDR(32'h0), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_len(req_len),
        .req_data0(req_data0), .req_data1(req_data1),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
        .done_valid(done_valid), .done_idx(done_idx), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; } bus_t;
    typedef struct { int idx; logic err; int lat; } done_t;
    typedef struct {
        int idx; logic [10:0] id; logic [7:0] len; logic [31:0] d0; logic [31:0] d1;
        int ready_at; logic [10:0] rx_xor; int slow_dly; logic exp_err;
    } vec_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    vec_t  vecs[5];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave configuration and state.
    int          ready_at = 1;       // poll number that first returns bit0=1; 0 = never
    logic [10:0] rx_xor   = '0;
    logic [31:0] slow_adr = 32'h10;
    int          slow_dly = 1;       // ack delay (cycles after first stb) for slow_adr; others 1
    int          s_cnt    = 0;
    int          polls    = 0;
    logic [10:0] last_id  = '0;
    logic [31:0] c_adr, c_dat, rd;
    logic        c_we, stable;
    bus_t        e_bus;

    always @(negedge clk) begin
        if (rst) begin
            wbm_ack_i = 1'b0;
            s_cnt     = 0;
        end else if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (s_cnt == 0) begin
                c_adr = wbm_adr_o; c_dat = wbm_dat_o; c_we = wbm_we_o; stable = 1'b1;
            end else if (wbm_adr_o !== c_adr || wbm_dat_o !== c_dat || wbm_we_o !== c_we) begin
                stable = 1'b0;
            end
            s_cnt++;
            if (s_cnt == ((wbm_adr_o == slow_adr) ? slow_dly : 1) + 1) begin
                s_cnt = 0;
                rd    = '0;
                if (wbm_we_o) begin
                    if (wbm_adr_o == 32'h08) last_id = wbm_dat_o[10:0];
                    if (wbm_adr_o == 32'h00) polls = 0;
                end else if (wbm_adr_o == 32'h04) begin
                    polls++;
                    rd = (ready_at != 0 && polls >= ready_at) ? 32'h1 : 32'h0;
                end else if (wbm_adr_o == 32'h18) begin
                    rd = {21'b0, last_id ^ rx_xor};
                end
                wbm_dat_i = rd;
                wbm_ack_i = 1'b1;
                check("stb hold stable", 32'(stable), 32'd1);
                if (bus_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected access: adr %h we %0d, none expected", wbm_adr_o, wbm_we_o);
                end else begin
                    e_bus = bus_q.pop_front();
                    check("bus adr", wbm_adr_o, e_bus.adr);
                    check("bus we", 32'(wbm_we_o), 32'(e_bus.we));
                    if (e_bus.we) check("bus wdat", wbm_dat_o, e_bus.dat);
                end
            end
        end
    end

    // Completion monitor: latency counted from the first busy cycle after grant.
    int    cyc_n = 0, t_start = 0;
    logic  busy_prev = 1'b0, done_prev = 1'b0;
    done_t e_done;

    always @(negedge clk) begin
        cyc_n++;
        if (busy && !busy_prev) t_start = cyc_n;
        if (done_prev) check("busy after done", 32'(busy), 32'd0);
        if (done_valid) begin
            if (done_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL spurious done: idx %0d err %0d, none expected", done_idx, done_err);
            end else begin
                e_done = done_q.pop_front();
                check("done_idx", 32'(done_idx), 32'(e_done.idx));
                check("done_err", 32'(done_err), 32'(e_done.err));
                check("grant-to-done cycles", 32'(cyc_n - t_start + 1), 32'(e_done.lat));
            end
        end
        busy_prev = busy;
        done_prev = done_valid;
    end

    task automatic set_mb(input int i, input logic [10:0] id, input logic [7:0] len,
                          input logic [31:0] d0, input logic [31:0] d1);
        req_id[i*11 +: 11]    = id;
        req_len[i*8 +: 8]     = len;
        req_data0[i*32 +: 32] = d0;
        req_data1[i*32 +: 32] = d1;
    endtask

    task automatic pulse(input logic [NUM_MB-1:0] mask);
        @(negedge clk);
        req_valid = mask;
        @(negedge clk);
        req_valid = '0;
    endtask

    function automatic int acc_cycles(input logic [31:0] adr);
        return ((adr == slow_adr) ? slow_dly : 1) + 2;
    endfunction

    // Expected bus trace and completion for one granted frame, using the current slave config.
    task automatic push_frame(input int idx, input logic [10:0] id, input logic [7:0] len,
                              input logic [31:0] d0, input logic [31:0] d1, input logic exp_err);
        bus_t  b;
        done_t d;
        int    lat = 1;
        int    n_poll = (ready_at == 0) ? POLL_MAX : ready_at;
        logic [31:0] wa[5];
        logic [31:0] wd[5];
        wa = '{32'h08, 32'h0C, 32'h10, 32'h14, 32'h00};
        wd = '{{21'b0, id}, {24'b0, len}, d0, d1, 32'h2};
        for (int k = 0; k < 5; k++) begin
            b.adr = wa[k]; b.we = 1'b1; b.dat = wd[k];
            bus_q.push_back(b);
            lat += acc_cycles(wa[k]);
        end
        for (int k = 0; k < n_poll; k++) begin
            b.adr = 32'h04; b.we = 1'b0; b.dat = '0;
            bus_q.push_back(b);
            lat += acc_cycles(32'h04);
        end
        if (ready_at != 0) begin
            b.adr = 32'h18; b.we = 1'b0; b.dat = '0; bus_q.push_back(b);
            b.adr = 32'h1C;                           bus_q.push_back(b);
            lat += acc_cycles(32'h18) + acc_cycles(32'h1C);
        end
        d.idx = idx; d.err = exp_err; d.lat = lat;
        done_q.push_back(d);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((done_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_vec++; n_err++;
            $display("FAIL wait_done: %0d completions still pending after %0d cycles", done_q.size(), budget);
            done_q.delete();
        end
        check("bus trace drained", 32'(bus_q.size()), 32'd0);
        bus_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwait;
        logic [10:0] arb_id[4];
        int          order[4];

        vecs[0] = '{idx: 2, id: 11'h123, len: 8'd8, d0: 32'hA5,       d1: 32'h5A,       ready_at: 1, rx_xor: 11'h000, slow_dly: 1, exp_err: 1'b0};
        vecs[1] = '{idx: 0, id: 11'h7FF, len: 8'd0, d0: 32'hFFFFFFFF, d1: 32'h00000000, ready_at: 3, rx_xor: 11'h000, slow_dly: 1, exp_err: 1'b0};
        vecs[2] = '{idx: 3, id: 11'h000, len: 8'd1, d0: 32'h12345678, d1: 32'h9ABCDEF0, ready_at: 0, rx_xor: 11'h000, slow_dly: 1, exp_err: 1'b1};
        vecs[3] = '{idx: 1, id: 11'h123, len: 8'd4, d0: 32'hDEADBEEF, d1: 32'hCAFEF00D, ready_at: 1, rx_xor: 11'h007, slow_dly: 1, exp_err: 1'b1};
        vecs[4] = '{idx: 1, id: 11'h2AA, len: 8'd2, d0: 32'h0F0F0F0F, d1: 32'hF0F0F0F0, ready_at: 2, rx_xor: 11'h000, slow_dly: 3, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'hF);
        check("reset cyc", 32'(wbm_cyc_o), 32'd0);
        check("reset stb", 32'(wbm_stb_o), 32'd0);
        check("reset adr", wbm_adr_o, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done_valid", 32'(done_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            ready_at = vecs[v].ready_at;
            rx_xor   = vecs[v].rx_xor;
            slow_dly = vecs[v].slow_dly;
            check("ready before load", 32'(req_ready[vecs[v].idx]), 32'd1);
            set_mb(vecs[v].idx, vecs[v].id, vecs[v].len, vecs[v].d0, vecs[v].d1);
            push_frame(vecs[v].idx, vecs[v].id, vecs[v].len, vecs[v].d0, vecs[v].d1, vecs[v].exp_err);
            pulse(4'(1 << vecs[v].idx));
            wait_done(2000);
            check("mailbox freed", 32'(req_ready), 32'hF);
        end

        // Arbitration: all four loaded in one cycle; lowest id first, ties by index.
        ready_at = 1; rx_xor = '0; slow_dly = 1;
        arb_id = '{11'h300, 11'h010, 11'h010, 11'h7FF};
        order  = '{1, 2, 0, 3};
        for (int i = 0; i < 4; i++)
            set_mb(i, arb_id[i], 8'(i + 1), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
        for (int i = 0; i < 4; i++)
            push_frame(order[i], arb_id[order[i]], 8'(order[i] + 1),
                       32'h1000 + 32'(order[i]), 32'h2000 + 32'(order[i]), 1'b0);
        pulse(4'hF);
        check("all mailboxes full", 32'(req_ready), 32'h0);
        wait_done(2000);
        check("arb mailboxes freed", 32'(req_ready), 32'hF);

        // Backpressure on WR_D0 with a rejected reload of the in-flight mailbox.
        slow_dly = 5;
        set_mb(1, 11'h055, 8'd3, 32'hAAAA5555, 32'h5555AAAA);
        push_frame(1, 11'h055, 8'd3, 32'hAAAA5555, 32'h5555AAAA, 1'b0);
        pulse(4'b0010);
        nwait = 0;
        while (!(wbm_stb_o && wbm_adr_o == 32'h10) && nwait < 200) begin
            @(negedge clk);
            nwait++;
        end
        check("reached WR_D0", 32'(nwait < 200), 32'd1);
        check("in-flight not ready", 32'(req_ready[1]), 32'd0);
        set_mb(1, 11'h001, 8'd9, 32'h11111111, 32'h22222222);
        pulse(4'b0010);
        wait_done(2000);
        check("bp mailbox freed", 32'(req_ready), 32'hF);
        slow_dly = 1;

        // Reset while polling: immediate abort, no completion, then a clean frame.
        ready_at = 0;
        set_mb(0, 11'h0AA, 8'd1, 32'h1, 32'h2);
        push_frame(0, 11'h0AA, 8'd1, 32'h1, 32'h2, 1'b1);
        pulse(4'b0001);
        nwait = 0;
        while (!(wbm_stb_o && wbm_adr_o == 32'h04) && nwait < 200) begin
            @(negedge clk);
            nwait++;
        end
        check("reached POLL", 32'(nwait < 200), 32'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst cyc low", 32'(wbm_cyc_o), 32'd0);
        check("rst stb low", 32'(wbm_stb_o), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'hF);
        check("rst done_valid", 32'(done_valid), 32'd0);
        bus_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle after reset", 32'(busy), 32'd0);
        ready_at = 1;
        set_mb(3, 11'h321, 8'd5, 32'hABCD0123, 32'h4567EF89);
        push_frame(3, 11'h321, 8'd5, 32'hABCD0123, 32'h4567EF89, 1'b0);
        pulse(4'b1000);
        wait_done(2000);
        check("post-reset freed", 32'(req_ready), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Wishbone-master sequencer sharing the CAN controller's single transmit path among NUM_MB requesters. Each requester owns a one-entry mailbox. Lowest CAN ID wins arbitration, as on a CAN bus. The winner's frame is programmed into the controller, the block polls for reception, reads back the received ID, and reports per-mailbox completion or error.

## Interface
- NUM_MB, 4: number of mailboxes/requesters; IDX_W = 2 covers it.
- BASE_ADDR, 32'h0: controller base; register offsets below are added to it.
- POLL_MAX, 16: status polls before timeout (≥1).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_MB  requester i offers a frame.
- req_ready  out  NUM_MB  mailbox i empty; frame accepted on valid&ready.
- req_id  in  NUM_MB*11  packed IDs, slice i = [i*11+:11].
- req_len  in  NUM_MB*8  packed lengths.
- req_data0, req_data1  in  NUM_MB*32 each  packed payload words.
- wbm_adr_o  out  32  bus address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1  Wishbone classic master controls.
- wbm_ack_i  in  1  slave acknowledge.
- done_valid  out  1  one-cycle completion pulse.
- done_idx  out  IDX_W  mailbox that completed.
- done_err  out  1  qualified by done_valid: timeout or ID mismatch.
- busy  out  1  high in any state other than IDLE.

## Operation
- Mailbox i loads id/len/data on req_valid[i]&req_ready[i]. req_ready[i] drops the next cycle and stays low until that mailbox completes.
- States: IDLE, WR_ID, WR_LEN, WR_D0, WR_D1, WR_CMD, POLL, RD_RXID, RD_CLR, DONE.
- IDLE: if any mailbox is full, grant the full mailbox with the smallest ID. Ties go to the lowest index. Latch the winning index, then go to WR_ID. The snapshot is taken at grant; later loads wait for the next round.
- Write sequence and offsets: WR_ID 0x08 {21'b0,id}, WR_LEN 0x0C {24'b0,len}, WR_D0 0x10 data0, WR_D1 0x14 data1, WR_CMD 0x00 32'h2.
- POLL: read 0x04.
  - If bit0=1, go to RD_RXID.
  - Otherwise increment poll_cnt. When poll_cnt reaches POLL_MAX, set err and go to DONE.
- RD_RXID: read 0x18 and compare [10:0] with the granted id. A mismatch sets err.
- RD_CLR: read 0x1C, which clears the controller's status and rx_ready. Ignore the data.
- DONE: pulse done_valid with done_idx/done_err, empty the mailbox (req_ready high next cycle), clear err and poll_cnt, return to IDLE.
- A mailbox can be reloaded only after its own done_valid. The mailbox in flight never changes mid-transaction.

## Timing
- Bus access:
  - Assert cyc=stb=1 with adr/we/dat stable until the cycle ack is sampled high.
  - Drop cyc/stb in the next cycle and hold them low for exactly one cycle before the next access.
  - With a slave that acks the cycle after stb, each access takes 3 cycles (stb high 2, gap 1).
- Read data is captured on the edge where ack is sampled.
- No timeout on ack; the block waits indefinitely.
- Grant to first stb is 1 cycle (IDLE→WR_ID edge, stb high that cycle).
- Fast slave, status ready on first poll: grant to done_valid = 8 accesses × 3 + 1 = 25 cycles.
- done_valid is high for exactly 1 cycle. busy falls the cycle after done_valid.
- Reset values:
  - All outputs 0 except req_ready = all ones.
  - All mailboxes empty, state IDLE, poll_cnt 0.
- Reset mid-transaction aborts immediately: cyc/stb drop asynchronously, no done_valid is issued, and the frame is lost.
- req_valid is ignored while ready=0. Load and completion of different mailboxes in the same cycle are independent.

## Test plan
- Single frame: mailbox 2, id 0x123, len 8, d0 0xA5, d1 0x5A; slave acks in 1 cycle, status=1 on first poll, rx_id reads 0x123 -> write sequence 0x08/0x0C/0x10/0x14/0x00 with data 0x123, 8, 0xA5, 0x5A, 0x2, then reads 0x04, 0x18, 0x1C; done_valid at cycle 25 after grant, done_idx=2, done_err=0.
- Arbitration: mailboxes 0..3 loaded same cycle with ids 0x300, 0x010, 0x010, 0x7FF -> completion order idx 1, 2, 0, 3.
- Timeout: status bit0 stays 0 -> exactly POLL_MAX=16 reads of 0x04, no 0x18/0x1C reads, done_err=1, mailbox freed.
- ID mismatch: rx_id returns 0x124 for tx 0x123 -> 0x1C still read, done_err=1.
- Backpressure: ack delayed 5 cycles on WR_D0 -> adr/dat/stb held stable throughout; reload of an in-flight mailbox rejected (ready=0) until its done_valid.
- Reset asserted during POLL -> cyc/stb low immediately, req_ready=4'hF, no done_valid; a new frame after reset completes normally.
